// File: rtl/wm_pixel_packer.sv
// Packs watermarked pixels two-per-word into a show-ahead FIFO with end-of-image tagging,
// per-frame pixel counting and sticky overflow / count-mismatch flags.
module wm_pixel_packer #(
    parameter int unsigned Amba_Word   = 16,
    parameter int unsigned Data_Depth  = 8,
    parameter int unsigned Fifo_Depth  = 16,
    parameter int unsigned Fifo_Addr   = 4,
    parameter int unsigned Count_Width = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_pixel,
    input  logic [Data_Depth-1:0]  Pixel_Data,
    input  logic                   Image_Done,
    input  logic [Data_Depth-1:0]  Np,
    output logic [Amba_Word-1:0]   out_data,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [Fifo_Addr:0]     fifo_level,
    output logic [Count_Width-1:0] pixel_count,
    output logic                   overflow,
    output logic                   count_err,
    output logic                   frame_done
);

    typedef enum logic [1:0] {S_LOW, S_HIGH, S_DONE} state_t;

    localparam logic [Fifo_Addr-1:0]   PtrOne = {{(Fifo_Addr-1){1'b0}}, 1'b1};
    localparam logic [Fifo_Addr:0]     LvlOne = {{Fifo_Addr{1'b0}}, 1'b1};
    localparam logic [Count_Width-1:0] CntOne = {{(Count_Width-1){1'b0}}, 1'b1};
    localparam logic [Data_Depth-1:0]  PadPix = '0;

    state_t                 r_state;
    logic                   r_done_q;
    logic [Data_Depth-1:0]  r_lo;
    logic [Count_Width-1:0] r_pixel_count;
    logic                   r_frame_done;
    logic                   r_count_err;

    // Stage register: a finished word waits here one cycle so its last bit is settled.
    logic                   r_stg_valid;
    logic [Amba_Word-1:0]   r_stg_data;
    logic                   r_stg_last;

    logic [Amba_Word-1:0]   r_mem      [Fifo_Depth];
    logic                   r_mem_last [Fifo_Depth];
    logic [Fifo_Addr-1:0]   r_wr_ptr;
    logic [Fifo_Addr-1:0]   r_rd_ptr;
    logic [Fifo_Addr:0]     r_level;
    logic                   r_overflow;

    logic                   w_rise;
    logic                   w_fall;
    logic                   w_acc;
    logic [Count_Width-1:0] w_cnt_next;
    logic [Count_Width-1:0] w_np_ext;
    logic [Count_Width-1:0] w_expected;
    logic                   w_stg_load;
    logic [Amba_Word-1:0]   w_stg_word;
    logic                   w_stg_last;
    logic                   w_mark_stg;
    logic                   w_mark_mem;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;

    assign w_rise     = Image_Done & ~r_done_q;
    assign w_fall     = ~Image_Done & r_done_q;
    assign w_acc      = new_pixel & (r_state != S_DONE);
    assign w_cnt_next = w_acc ? r_pixel_count + CntOne : r_pixel_count;
    assign w_np_ext   = {{(Count_Width-Data_Depth){1'b0}}, Np};
    assign w_expected = w_np_ext * w_np_ext;

    assign w_empty = (r_level == '0);
    // Level never exceeds the power-of-two depth, so its MSB alone means full.
    assign w_full  = r_level[Fifo_Addr];
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = r_stg_valid & (~w_full | w_pop);
    assign w_drop  = r_stg_valid & w_full & ~w_pop;

    always_comb begin
        w_stg_load = 1'b0;
        w_stg_word = '0;
        w_stg_last = 1'b0;
        w_mark_stg = 1'b0;
        w_mark_mem = 1'b0;
        case (r_state)
            S_LOW: begin
                if (new_pixel && w_rise) begin
                    w_stg_load = 1'b1;
                    w_stg_word = {PadPix, Pixel_Data};
                    w_stg_last = 1'b1;
                end else if (w_rise && (r_pixel_count != '0)) begin
                    // Even frame: the final word is either leaving the stage now or already queued.
                    if (r_stg_valid) begin
                        w_mark_stg = 1'b1;
                    end else if (!w_empty) begin
                        w_mark_mem = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (new_pixel) begin
                    w_stg_load = 1'b1;
                    w_stg_word = {Pixel_Data, r_lo};
                    w_stg_last = w_rise;
                end else if (w_rise) begin
                    w_stg_load = 1'b1;
                    w_stg_word = {PadPix, r_lo};
                    w_stg_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_LOW;
            r_done_q      <= 1'b0;
            r_lo          <= '0;
            r_pixel_count <= '0;
            r_frame_done  <= 1'b0;
            r_count_err   <= 1'b0;
            r_stg_valid   <= 1'b0;
            r_stg_data    <= '0;
            r_stg_last    <= 1'b0;
        end else begin
            r_done_q    <= Image_Done;
            r_stg_valid <= w_stg_load;
            r_stg_data  <= w_stg_word;
            r_stg_last  <= w_stg_last;
            case (r_state)
                S_LOW, S_HIGH: begin
                    if (new_pixel) begin
                        r_pixel_count <= w_cnt_next;
                        if (r_state == S_LOW) begin
                            r_lo <= Pixel_Data;
                        end
                    end
                    if (w_rise) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                        if (w_cnt_next != w_expected) begin
                            r_count_err <= 1'b1;
                        end
                    end else if (new_pixel) begin
                        r_state <= (r_state == S_LOW) ? S_HIGH : S_LOW;
                    end
                end
                S_DONE: begin
                    if (w_fall) begin
                        r_state       <= S_LOW;
                        r_pixel_count <= '0;
                        r_frame_done  <= 1'b0;
                    end
                end
                default: r_state <= S_LOW;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LvlOne;
                2'b01:   r_level <= r_level - LvlOne;
                default: ;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: outputs are gated by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= r_stg_data;
            r_mem_last[r_wr_ptr] <= r_stg_last | w_mark_stg;
        end
        if (w_mark_mem) begin
            r_mem_last[r_wr_ptr - PtrOne] <= 1'b1;
        end
    end

    assign out_valid   = ~w_empty;
    assign out_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign out_last    = ~w_empty & r_mem_last[r_rd_ptr];
    assign fifo_level  = r_level;
    assign pixel_count = r_pixel_count;
    assign overflow    = r_overflow;
    assign count_err   = r_count_err;
    assign frame_done  = r_frame_done;

endmodule
